// File: rtl/next_pc_unit.sv
// Next-PC selector with a circular return-address stack for call/ret.
// Latency: nextPC/holdPC are combinational; stack, depth and flags update on the next clk edge.
// Backpressure: stall freezes everything (nextPC = currentPC, holdPC = 1, no stack update).
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   currentPC                : PC currently held by the program counter stage
//   stall                    : pipeline stall request, forwarded as holdPC
//   branch_taken/_target     : taken conditional branch
//   jump/jump_target         : unconditional jump
//   call/call_target         : subroutine call, pushes currentPC+1
//   ret                      : subroutine return, pops top of stack
//   nextPC, holdPC           : to the program counter stage
//   ras_depth                : number of valid stack entries
//   ras_overflow/_underflow  : sticky push-while-full / pop-while-empty flags

module next_pc_unit #(
   parameter int RAS_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] currentPC,
   input  logic       stall,
   input  logic       branch_taken,
   input  logic [7:0] branch_target,
   input  logic       jump,
   input  logic [7:0] jump_target,
   input  logic       call,
   input  logic [7:0] call_target,
   input  logic       ret,
   output logic [7:0] nextPC,
   output logic       holdPC,
   output logic [3:0] ras_depth,
   output logic       ras_overflow,
   output logic       ras_underflow
);

   localparam int         PTR_W     = $clog2(RAS_DEPTH);
   localparam logic [3:0] DEPTH_MAX = 4'(RAS_DEPTH);

   // wr_ptr_q is the slot the next push writes; the top of stack sits one below it.
   // Because RAS_DEPTH is a power of two the pointer wraps naturally, which gives
   // the overwrite-oldest behaviour on a full push and keeps LIFO order afterwards.
   logic [7:0]       stack_q [RAS_DEPTH];
   logic [7:0]       stack_d [RAS_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] top_idx;
   logic [3:0]       depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [7:0] pc_inc;
   logic       empty;
   logic       full;
   logic       do_push;
   logic       do_pop;

   assign pc_inc  = currentPC + 8'd1;
   assign top_idx = wr_ptr_q - PTR_W'(1);
   assign empty   = (depth_q == 4'd0);
   assign full    = (depth_q == DEPTH_MAX);

   // ret outranks call, so a simultaneous call is simply dropped.
   assign do_pop  = !stall && ret && !empty;
   assign do_push = !stall && !ret && call;

   always_comb begin
      nextPC = pc_inc;
      if (stall) begin
         nextPC = currentPC;
      end else if (ret) begin
         nextPC = empty ? pc_inc : stack_q[top_idx];
      end else if (call) begin
         nextPC = call_target;
      end else if (jump) begin
         nextPC = jump_target;
      end else if (branch_taken) begin
         nextPC = branch_target;
      end
   end

   assign holdPC = stall;

   always_comb begin
      stack_d  = stack_q;
      wr_ptr_d = wr_ptr_q;
      depth_d  = depth_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (do_push) begin
         stack_d[wr_ptr_q] = pc_inc;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            depth_d = depth_q + 4'd1;
         end
      end else if (do_pop) begin
         wr_ptr_d = top_idx;
         depth_d  = depth_q - 4'd1;
      end else if (!stall && ret && empty) begin
         unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            stack_q[i] <= 8'h00;
         end
         wr_ptr_q <= '0;
         depth_q  <= 4'd0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         depth_q  <= depth_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign ras_depth     = depth_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Table-driven bench for next_pc_unit (RAS_DEPTH = 4).
// Each vector is driven after a falling edge; nextPC/holdPC are checked for those
// inputs and ras_depth/flags are checked as they stand before the following rising edge.

module tb_next_pc_unit;

   logic       clk;
   logic       rst;
   logic [7:0] currentPC;
   logic       stall;
   logic       branch_taken;
   logic [7:0] branch_target;
   logic       jump;
   logic [7:0] jump_target;
   logic       call;
   logic [7:0] call_target;
   logic       ret;
   logic [7:0] nextPC;
   logic       holdPC;
   logic [3:0] ras_depth;
   logic       ras_overflow;
   logic       ras_underflow;

   next_pc_unit #(.RAS_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .currentPC     (currentPC),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .call          (call),
      .call_target   (call_target),
      .ret           (ret),
      .nextPC        (nextPC),
      .holdPC        (holdPC),
      .ras_depth     (ras_depth),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] pc;
      logic       stall;
      logic       br;
      logic [7:0] bt;
      logic       jmp;
      logic [7:0] jt;
      logic       cl;
      logic [7:0] ct;
      logic       rt;
      logic [7:0] e_npc;
      logic       e_hold;
      logic [3:0] e_depth;
      logic       e_ovf;
      logic       e_unf;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input logic r, input logic [7:0] pc, input logic st,
                      input logic br, input logic [7:0] bt,
                      input logic jmp, input logic [7:0] jt,
                      input logic cl, input logic [7:0] ct, input logic rt,
                      input logic [7:0] e_npc, input logic e_hold,
                      input logic [3:0] e_depth, input logic e_ovf, input logic e_unf);
      vec_t v;
      v.rst = r;  v.pc = pc; v.stall = st; v.br = br; v.bt = bt;
      v.jmp = jmp; v.jt = jt; v.cl = cl; v.ct = ct; v.rt = rt;
      v.e_npc = e_npc; v.e_hold = e_hold; v.e_depth = e_depth;
      v.e_ovf = e_ovf; v.e_unf = e_unf;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst           = v.rst;
      currentPC     = v.pc;
      stall         = v.stall;
      branch_taken  = v.br;
      branch_target = v.bt;
      jump          = v.jmp;
      jump_target   = v.jt;
      call          = v.cl;
      call_target   = v.ct;
      ret           = v.rt;
   endtask

   initial begin
      //   rst pc     st br bt     j  jt     c  ct     r   npc    h  d  o  u
      add(0, 8'h10, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  8'h11, 0, 0, 0, 0); // 0 sequential
      add(0, 8'hFF, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  8'h00, 0, 0, 0, 0); // 1 wrap
      add(0, 8'h20, 0, 0, 8'h00, 0, 8'h00, 1, 8'h80, 0,  8'h80, 0, 0, 0, 0); // 2 call, push 21
      add(0, 8'h85, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h21, 0, 1, 0, 0); // 3 ret
      add(0, 8'h40, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  8'h41, 0, 0, 0, 0); // 4
      add(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 8'h90, 0,  8'h90, 0, 0, 0, 0); // 5 push 01
      add(0, 8'h01, 0, 0, 8'h00, 0, 8'h00, 1, 8'h90, 0,  8'h90, 0, 1, 0, 0); // 6 push 02
      add(0, 8'h02, 0, 0, 8'h00, 0, 8'h00, 1, 8'h90, 0,  8'h90, 0, 2, 0, 0); // 7 push 03
      add(0, 8'h03, 0, 0, 8'h00, 0, 8'h00, 1, 8'h90, 0,  8'h90, 0, 3, 0, 0); // 8 push 04
      add(0, 8'h04, 0, 0, 8'h00, 0, 8'h00, 1, 8'h90, 0,  8'h90, 0, 4, 0, 0); // 9 push 05 while full
      add(0, 8'h50, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h05, 0, 4, 1, 0); // 10
      add(0, 8'h50, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h04, 0, 3, 1, 0); // 11
      add(0, 8'h50, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h03, 0, 2, 1, 0); // 12
      add(0, 8'h50, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h02, 0, 1, 1, 0); // 13
      add(0, 8'h60, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h61, 0, 0, 1, 0); // 14 underflow
      add(0, 8'h30, 1, 0, 8'h00, 1, 8'h77, 1, 8'hA0, 0,  8'h30, 1, 0, 1, 1); // 15 stall wins
      add(0, 8'h30, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  8'h31, 0, 0, 1, 1); // 16
      add(0, 8'h70, 0, 1, 8'h33, 0, 8'h00, 0, 8'h00, 0,  8'h33, 0, 0, 1, 1); // 17 branch
      add(0, 8'h70, 0, 1, 8'h33, 1, 8'h55, 0, 8'h00, 0,  8'h55, 0, 0, 1, 1); // 18 jump > branch
      add(0, 8'h70, 0, 1, 8'h33, 1, 8'h55, 1, 8'hAA, 0,  8'hAA, 0, 0, 1, 1); // 19 call > jump, push 71
      add(0, 8'h10, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h10, 1, 1, 1, 1); // 20 stalled ret
      add(0, 8'h10, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  8'h11, 0, 1, 1, 1); // 21
      add(0, 8'h12, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h71, 0, 1, 1, 1); // 22
      add(0, 8'h43, 0, 0, 8'h00, 0, 8'h00, 1, 8'h99, 0,  8'h99, 0, 0, 1, 1); // 23 push 44
      add(0, 8'h00, 0, 0, 8'h00, 1, 8'h22, 1, 8'h11, 1,  8'h44, 0, 1, 1, 1); // 24 ret > call > jump
      add(0, 8'h05, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  8'h06, 0, 0, 1, 1); // 25 call discarded
      add(1, 8'h08, 0, 0, 8'h00, 0, 8'h00, 1, 8'h66, 0,  8'h66, 0, 0, 1, 1); // 26 call under reset
      add(0, 8'h08, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  8'h09, 0, 0, 0, 0); // 27 flags cleared
      add(0, 8'h10, 0, 0, 8'h00, 0, 8'h00, 1, 8'h20, 0,  8'h20, 0, 0, 0, 0); // 28 push 11
      add(1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h11, 0, 1, 0, 0); // 29 ret during reset
      add(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  8'h01, 0, 0, 0, 0); // 30 stack emptied
      add(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  8'h01, 0, 0, 0, 1); // 31

      // Reset sequence, then check the state it leaves behind.
      drive(vecs[0]);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_depth", -1, 8'(ras_depth), 8'h00);
      chk("rst_ovf",   -1, 8'(ras_overflow), 8'h00);
      chk("rst_unf",   -1, 8'(ras_underflow), 8'h00);
      chk("rst_hold",  -1, 8'(holdPC), 8'h00);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk("nextPC",    i, nextPC, vecs[i].e_npc);
         chk("holdPC",    i, 8'(holdPC), 8'(vecs[i].e_hold));
         chk("ras_depth", i, 8'(ras_depth), 8'(vecs[i].e_depth));
         chk("overflow",  i, 8'(ras_overflow), 8'(vecs[i].e_ovf));
         chk("underflow", i, 8'(ras_underflow), 8'(vecs[i].e_unf));
      end

      // Refill past capacity twice to exercise repeated wrap, then drain in LIFO order.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      ret   = 1'b0;
      call  = 1'b1;
      call_target = 8'hC0;
      for (int k = 0; k < 7; k++) begin
         currentPC = 8'(8'h20 + k);          // pushes 21..27
         @(negedge clk);
      end
      call = 1'b0;
      #1;
      chk("wrap_depth", -2, 8'(ras_depth), 8'h04);
      chk("wrap_ovf",   -2, 8'(ras_overflow), 8'h01);
      ret = 1'b1;
      currentPC = 8'hE0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("wrap_pop", k, nextPC, 8'(8'h27 - k));
         @(negedge clk);
      end
      #1;
      chk("wrap_empty", -2, nextPC, 8'hE1);
      chk("wrap_unf_pre", -2, 8'(ras_underflow), 8'h00);
      @(negedge clk);
      ret = 1'b0;
      #1;
      chk("wrap_unf", -2, 8'(ras_underflow), 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
